addsub_serial_ctrl: RTL and testbench

Multi-cycle controller that performs WIDTH-bit add/subtract by sequencing one shared 4-bit add/sub slice over WIDTH/4 nibbles, least-significant nibble first. The carry is registered between nibbles. A start/busy/done handshake lets a host issue wide arithmetic without building a WIDTH-bit ripple chain. It sits between the host control logic and the nibble add/sub datapath.

---
 rtl/addsub_pkg.sv | 7 +
 rtl/addsub_serial_ctrl_if.sv | 19 +
 rtl/addsub_nibble.sv | 21 ++
 rtl/addsub_serial_ctrl.sv | 96 +++++++++
 tb/tb_addsub_serial_ctrl.sv | 182 ++++++++++++++++++
 5 files changed

// File: rtl/addsub_pkg.sv
// addsub_pkg: shared state encoding and constants for the serial add/sub controller
package addsub_pkg;
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
    localparam logic MODE_ADD = 1'b0;
    localparam logic MODE_SUB = 1'b1;
    localparam int NIBBLE_W = 4;
endpackage

// File: rtl/addsub_serial_ctrl_if.sv
// addsub_serial_ctrl_if: host-side handshake/operand bus; overflow present when ADDSUB_OVERFLOW_FLAG_EN is defined
interface addsub_serial_ctrl_if #(parameter int WIDTH = 16);
    logic             start;
    logic             mode;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             busy;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             carry_out;
`ifdef ADDSUB_OVERFLOW_FLAG_EN
    logic             overflow;
    modport master (output start, mode, a, b, input busy, done, result, carry_out, overflow);
    modport slave  (input start, mode, a, b, output busy, done, result, carry_out, overflow);
`else
    modport master (output start, mode, a, b, input busy, done, result, carry_out);
    modport slave  (input start, mode, a, b, output busy, done, result, carry_out);
`endif
endinterface

// File: rtl/addsub_nibble.sv
// addsub_nibble: combinational 4-bit ripple slice of full-adder cells; c3 is the carry into bit 3
module addsub_nibble
    import addsub_pkg::*;
(
    input  logic [NIBBLE_W-1:0] x,
    input  logic [NIBBLE_W-1:0] y,
    input  logic                cin,
    output logic [NIBBLE_W-1:0] s,
    output logic                cout,
    output logic                c3
);
    logic [NIBBLE_W:0] c;

    assign c[0] = cin;
    for (genvar i = 0; i < NIBBLE_W; i++) begin : g_fa
        assign s[i]   = x[i] ^ y[i] ^ c[i];
        assign c[i+1] = (x[i] & y[i]) | (c[i] & (x[i] ^ y[i]));
    end
    assign cout = c[NIBBLE_W];
    assign c3   = c[NIBBLE_W-1];
endmodule

// File: rtl/addsub_serial_ctrl.sv
// addsub_serial_ctrl: WIDTH-bit add/sub over one shared nibble slice, LS nibble first; optional ADDSUB_OVERFLOW_FLAG_EN adds the signed overflow flag
module addsub_serial_ctrl
    import addsub_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input logic                 clk,
    input logic                 rst_n,
    addsub_serial_ctrl_if.slave bus
);
    localparam int NIB = WIDTH / NIBBLE_W;
    localparam int IW = (NIB > 1) ? $clog2(NIB) : 1;
    localparam logic [IW-1:0] LAST = IW'(NIB - 1);

    state_t                       state, state_n;
    logic [NIB-1:0][NIBBLE_W-1:0] ra, rb, res;
    logic [IW-1:0]                idx;
    logic                         rmode, cy, co_r, accept, last;
    logic [NIBBLE_W-1:0]          s_sum;
    logic                         s_cout;
`ifdef ADDSUB_OVERFLOW_FLAG_EN
    logic                         s_c3, ov_r;
`else
    logic                         c3_unused;
`endif

    assign accept = bus.start && (state == IDLE || state == DONE);
    assign last   = idx == LAST;

    addsub_nibble u_nib (
        .x    (ra[idx]),
        .y    ((rmode == MODE_SUB) ? ~rb[idx] : rb[idx]),
        .cin  (cy),
`ifdef ADDSUB_OVERFLOW_FLAG_EN
        .c3   (s_c3),
`else
        .c3   (c3_unused),
`endif
        .s    (s_sum),
        .cout (s_cout)
    );

    // next state: starts win in IDLE/DONE, RUN leaves after the last nibble
    always_comb begin
        state_n = state;
        if (accept) state_n = RUN;
        else if (state == RUN && last) state_n = DONE;
        else if (state == DONE) state_n = IDLE;
    end

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else state <= state_n;
    end

    // operand latch on accept, then one nibble per RUN cycle with the carry chained through cy
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ra    <= '0;
            rb    <= '0;
            res   <= '0;
            rmode <= 1'b0;
            cy    <= 1'b0;
            idx   <= '0;
            co_r  <= 1'b0;
`ifdef ADDSUB_OVERFLOW_FLAG_EN
            ov_r  <= 1'b0;
`endif
        end else if (accept) begin
            ra    <= bus.a;
            rb    <= bus.b;
            rmode <= bus.mode;
            cy    <= bus.mode;
            idx   <= '0;
        end else if (state == RUN) begin
            res[idx] <= s_sum;
            cy       <= s_cout;
            idx      <= idx + IW'(1);
            if (last) begin
                co_r <= s_cout;
`ifdef ADDSUB_OVERFLOW_FLAG_EN
                ov_r <= s_c3 ^ s_cout;
`endif
            end
        end
    end

    assign bus.busy      = state == RUN;
    assign bus.done      = state == DONE;
    assign bus.result    = res;
    assign bus.carry_out = co_r;
`ifdef ADDSUB_OVERFLOW_FLAG_EN
    assign bus.overflow  = ov_r;
`endif
endmodule

// File: tb/tb_addsub_serial_ctrl.sv
// tb_addsub_serial_ctrl: directed and random checks of the serial add/sub controller against an arithmetic model
module tb_addsub_serial_ctrl;
    localparam int WIDTH = 16;
    localparam int NIB = WIDTH / 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    int checks = 0;
    int passed = 0;
    int fails = 0;

    addsub_serial_ctrl_if #(.WIDTH(WIDTH)) bus ();
    addsub_serial_ctrl #(.WIDTH(WIDTH)) dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passed++;
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // {carry_out, result}: carry is the unsigned carry for add, "no borrow" (a >= b) for subtract
    function automatic logic [16:0] model(input logic [15:0] a, input logic [15:0] b, input logic m);
        logic [31:0] ua, ub, r;
        ua = {16'd0, a};
        ub = {16'd0, b};
        r = m ? ua - ub : ua + ub;
        return {m ? (ua >= ub) : r[16], r[15:0]};
    endfunction

    function automatic logic ovf(input logic [15:0] a, input logic [15:0] b, input logic m);
        int s;
        s = m ? int'($signed(a)) - int'($signed(b)) : int'($signed(a)) + int'($signed(b));
        return (s > 32767) || (s < -32768);
    endfunction

    // issue one op (accepted at the next edge), scramble inputs during RUN, wait for done and check
    task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b, input logic m);
        logic [16:0] e;
        int c;
        e = model(a, b, m);
        bus.a = a;
        bus.b = b;
        bus.mode = m;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        c = 1;
        check({tag, " busy"}, {31'd0, bus.busy}, 32'd1);
        bus.a = 16'($urandom);
        bus.b = 16'($urandom);
        bus.mode = 1'($urandom_range(0, 1));
        while (!bus.done && c < 4 * NIB + 8) begin
            tick();
            c++;
        end
        check({tag, " latency"}, c, NIB + 1);
        check({tag, " busy@done"}, {31'd0, bus.busy}, 32'd0);
        check({tag, " result"}, {16'd0, bus.result}, {16'd0, e[15:0]});
        check({tag, " carry"}, {31'd0, bus.carry_out}, {31'd0, e[16]});
`ifdef ADDSUB_OVERFLOW_FLAG_EN
        check({tag, " ovf"}, {31'd0, bus.overflow}, {31'd0, ovf(a, b, m)});
`endif
    endtask

    initial begin
        int extra;
        logic [16:0] e;
        logic [15:0] ra, rb;
        logic rm;
        bus.start = 1'b0;
        bus.mode = 1'b0;
        bus.a = '0;
        bus.b = '0;
        repeat (2) tick();
        check("rst busy", {31'd0, bus.busy}, 32'd0);
        check("rst done", {31'd0, bus.done}, 32'd0);
        check("rst result", {16'd0, bus.result}, 32'd0);
        check("rst carry", {31'd0, bus.carry_out}, 32'd0);
        rst_n = 1'b1;
        tick();
        check("idle busy", {31'd0, bus.busy}, 32'd0);

        run_op("add", 16'h1234, 16'h0FCC, 1'b0);
        check("add const", {16'd0, bus.result}, 32'h2200);
        tick();
        check("done pulse", {31'd0, bus.done}, 32'd0);
        check("held result", {16'd0, bus.result}, 32'h2200);
        run_op("wrap", 16'hFFFF, 16'h0001, 1'b0);
        check("wrap const", {15'd0, bus.carry_out, bus.result}, 32'h10000);
        run_op("borrow", 16'h0005, 16'h0007, 1'b1);
        check("borrow const", {15'd0, bus.carry_out, bus.result}, 32'h0FFFE);
        run_op("sub80", 16'h8000, 16'h0001, 1'b1);
        check("sub80 const", {15'd0, bus.carry_out, bus.result}, 32'h17FFF);
        tick();

        // start pulse two cycles into RUN must be ignored
        bus.a = 16'h1234;
        bus.b = 16'h0FCC;
        bus.mode = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        bus.a = 16'h1111;
        bus.b = 16'h1111;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        check("ign busy", {31'd0, bus.busy}, 32'd1);
        extra = 3;
        while (!bus.done && extra < 20) begin
            tick();
            extra++;
        end
        check("ign latency", extra, NIB + 1);
        check("ign result", {16'd0, bus.result}, 32'h2200);
        extra = 0;
        repeat (8) begin
            tick();
            if (bus.done) extra++;
        end
        check("ign single done", extra, 0);

        // back-to-back: second op starts in the DONE cycle of the first
        run_op("b2b1", 16'h1234, 16'h0FCC, 1'b0);
        run_op("b2b2", 16'h0003, 16'h0001, 1'b1);
        check("b2b const", {15'd0, bus.carry_out, bus.result}, 32'h10002);
        tick();

        // reset in the second RUN cycle
        bus.a = 16'hABCD;
        bus.b = 16'h1357;
        bus.mode = 1'b0;
        bus.start = 1'b1;
        tick();
        bus.start = 1'b0;
        tick();
        #2 rst_n = 1'b0;
        #1;
        check("mid rst busy", {31'd0, bus.busy}, 32'd0);
        check("mid rst result", {16'd0, bus.result}, 32'd0);
        check("mid rst carry", {31'd0, bus.carry_out}, 32'd0);
        extra = 0;
        repeat (3) begin
            tick();
            if (bus.done) extra++;
        end
        rst_n = 1'b1;
        repeat (6) begin
            tick();
            if (bus.done) extra++;
        end
        check("mid rst no done", extra, 0);
        run_op("post rst", 16'hABCD, 16'h1357, 1'b0);

        // random ops, sometimes from IDLE, sometimes back-to-back
        for (int i = 0; i < 24; i++) begin
            ra = 16'($urandom);
            rb = (i % 5 == 0) ? ra : 16'($urandom);
            rm = 1'($urandom_range(0, 1));
            run_op("rand", ra, rb, rm);
            if ($urandom_range(0, 1) == 1) begin
                e = model(ra, rb, rm);
                repeat (2) tick();
                check("rand held", {15'd0, bus.carry_out, bus.result}, {15'd0, e});
            end
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end
endmodule
